request_encoder_8_3: RTL and testbench

REQUEST_ENCODER_8_3 -- requirements
Module: request_encoder_8_3

---
 rtl/encoder_pkg.sv | 12 +
 rtl/prio_enc_8_3.sv | 29 ++
 rtl/request_encoder_8_3.sv | 101 ++++++++++
 tb/tb_request_encoder_8_3.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared widths and FSM state type for the 8-to-3 request encoder.
package encoder_pkg;

    localparam int IN_WIDTH  = 8;
    localparam int IDX_WIDTH = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/prio_enc_8_3.sv
// Combinational selector: returns the first set bit of vector, searching
// upward from base and wrapping 7->0. With base=0 this is plain
// lowest-index-wins priority.
module prio_enc_8_3
    import encoder_pkg::*;
(
    input  logic [IN_WIDTH-1:0]  vector,
    input  logic [IDX_WIDTH-1:0] base,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 any
);

    logic [IDX_WIDTH-1:0] pos;

    // Walk positions base, base+1, ... (mod 8) and keep the first hit.
    always_comb begin
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            pos = base + i[IDX_WIDTH-1:0];
            if (!any && vector[pos]) begin
                idx = pos;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/request_encoder_8_3.sv
// Request encoder: captures request bits into a pending set and presents
// them one index at a time through a valid/ready output register.
// Define REQUEST_ENCODER_ROUND_ROBIN_EN to make the search start at a
// rotating pointer instead of always at bit 0.
module request_encoder_8_3
    import encoder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [IN_WIDTH-1:0]  req,
    output logic [IDX_WIDTH-1:0] out_idx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IN_WIDTH-1:0]  pending
);

    state_t               state_q, state_d;
    logic [IN_WIDTH-1:0]  pending_q, pending_d;
    logic [IDX_WIDTH-1:0] out_idx_q, out_idx_d;
    logic [IDX_WIDTH-1:0] base;
    logic [IDX_WIDTH-1:0] sel_idx;
    logic                 sel_any;
    logic                 load;
    logic [IN_WIDTH-1:0]  load_mask;

`ifdef REQUEST_ENCODER_ROUND_ROBIN_EN
    logic [IDX_WIDTH-1:0] ptr_q, ptr_d;

    assign base = ptr_q;

    // Pointer moves just past whatever index was loaded last.
    always_comb begin
        ptr_d = ptr_q;
        if (load) ptr_d = sel_idx + 3'd1;
    end

    // Pointer register, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`else
    assign base = '0;
`endif

    // Selection looks only at registered pending bits, never at req.
    prio_enc_8_3 u_sel (
        .vector (pending_q),
        .base   (base),
        .idx    (sel_idx),
        .any    (sel_any)
    );

    // Next state, load decision and pending update. New captures are ORed
    // after the clear so a bit arriving as it is loaded stays pending.
    always_comb begin
        state_d   = state_q;
        out_idx_d = out_idx_q;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_any) begin
                    load    = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    if (sel_any) load    = 1'b1;
                    else         state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        load_mask = '0;
        if (load) begin
            load_mask[sel_idx] = 1'b1;
            out_idx_d          = sel_idx;
        end
        pending_d = (pending_q & ~load_mask) | (en ? req : '0);
    end

    // State, pending set and output index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            out_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            out_idx_q <= out_idx_d;
        end
    end

    assign out_valid = (state_q == PRESENT);
    assign out_idx   = out_idx_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_request_encoder_8_3.sv
// Directed bench for request_encoder_8_3; expected values are hand-derived.
module tb_request_encoder_8_3;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [2:0] out_idx;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] pending;

    int n_vec = 0;
    int n_err = 0;

`ifdef REQUEST_ENCODER_ROUND_ROBIN_EN
    localparam logic [2:0] RR_A = 3'd5;
    localparam logic [2:0] RR_B = 3'd0;
`else
    localparam logic [2:0] RR_A = 3'd0;
    localparam logic [2:0] RR_B = 3'd5;
`endif

    request_encoder_8_3 dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle before sampling and driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input string tag, input logic v, input logic [2:0] idx, input logic [7:0] p);
        chk({tag, ".valid"}, {7'd0, out_valid}, {7'd0, v});
        if (v) chk({tag, ".idx"}, {5'd0, out_idx}, {5'd0, idx});
        chk({tag, ".pend"}, pending, p);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; req = 8'h00; out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; req = 8'hFF; out_ready = 1'b1;
        tick();
        // Reset state, with req discarded during reset
        chk("rst.valid", {7'd0, out_valid}, 8'd0);
        chk("rst.idx", {5'd0, out_idx}, 8'd0);
        chk("rst.pend", pending, 8'h00);
        rst = 1'b0; en = 1'b0; req = 8'h00;
        tick();
        st("rst.after", 1'b0, 3'd0, 8'h00);

        // Single request
        do_reset();
        en = 1'b1; req = 8'h10; out_ready = 1'b1;
        tick(); st("single.cap", 1'b0, 3'd0, 8'h10);
        en = 1'b0; req = 8'h00;
        tick(); st("single.out", 1'b1, 3'd4, 8'h00);
        tick(); st("single.idle", 1'b0, 3'd0, 8'h00);

        // Fixed-priority burst, back-to-back
        do_reset();
        en = 1'b1; req = 8'hA5; out_ready = 1'b1;
        tick(); st("burst.cap", 1'b0, 3'd0, 8'hA5);
        en = 1'b0; req = 8'h00;
        tick(); st("burst.0", 1'b1, 3'd0, 8'hA4);
        tick(); st("burst.2", 1'b1, 3'd2, 8'hA0);
        tick(); st("burst.5", 1'b1, 3'd5, 8'h80);
        tick(); st("burst.7", 1'b1, 3'd7, 8'h00);
        tick(); st("burst.idle", 1'b0, 3'd0, 8'h00);

        // Backpressure holds output stable
        do_reset();
        en = 1'b1; req = 8'h06; out_ready = 1'b0;
        tick(); st("bp.cap", 1'b0, 3'd0, 8'h06);
        en = 1'b0; req = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick(); st("bp.hold", 1'b1, 3'd1, 8'h04);
        end
        out_ready = 1'b1;
        tick(); st("bp.2", 1'b1, 3'd2, 8'h00);
        tick(); st("bp.idle", 1'b0, 3'd0, 8'h00);

        // en=0 blocks capture
        do_reset();
        en = 1'b0; req = 8'hFF; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); st("gate", 1'b0, 3'd0, 8'h00);
        end

        // Set wins over clear: re-request of the index being loaded
        do_reset();
        en = 1'b1; req = 8'h01; out_ready = 1'b0;
        tick(); st("setw.cap", 1'b0, 3'd0, 8'h01);
        tick(); st("setw.load", 1'b1, 3'd0, 8'h01);
        en = 1'b0; req = 8'h00; out_ready = 1'b1;
        tick(); st("setw.again", 1'b1, 3'd0, 8'h00);
        tick(); st("setw.idle", 1'b0, 3'd0, 8'h00);

        // Reset mid-burst
        do_reset();
        en = 1'b1; req = 8'hFF; out_ready = 1'b1;
        tick(); st("rmid.cap", 1'b0, 3'd0, 8'hFF);
        en = 1'b0; req = 8'h00;
        tick(); st("rmid.0", 1'b1, 3'd0, 8'hFE);
        tick(); st("rmid.1", 1'b1, 3'd1, 8'hFC);
        rst = 1'b1;
        tick();
        chk("rmid.valid", {7'd0, out_valid}, 8'd0);
        chk("rmid.pend", pending, 8'h00);
        chk("rmid.idx", {5'd0, out_idx}, 8'd0);
        rst = 1'b0;

        // Pointer behaviour: grant 3, then 0 and 3, then 0/5 order depends on build
        do_reset();
        en = 1'b1; req = 8'h08; out_ready = 1'b1;
        tick(); st("rr.cap", 1'b0, 3'd0, 8'h08);
        en = 1'b0; req = 8'h00;
        tick(); st("rr.3", 1'b1, 3'd3, 8'h00);
        en = 1'b1; req = 8'h09;
        tick(); st("rr.cap9", 1'b0, 3'd0, 8'h09);
        en = 1'b0; req = 8'h00;
        tick(); st("rr.9a", 1'b1, 3'd0, 8'h08);
        tick(); st("rr.9b", 1'b1, 3'd3, 8'h00);
        tick(); st("rr.idle", 1'b0, 3'd0, 8'h00);
        en = 1'b1; req = 8'h21;
        tick(); st("rr.cap21", 1'b0, 3'd0, 8'h21);
        en = 1'b0; req = 8'h00;
        tick(); st("rr.21a", 1'b1, RR_A, 8'h21 & ~(8'h01 << RR_A));
        tick(); st("rr.21b", 1'b1, RR_B, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
